// File: rtl/cmp_node_mem.sv
// Four-node CMP memory subsystem: per-node IMEM/DMEM with combinational reads, completion detect, cycle counter.
// Optional macro DMEM_WR_BYPASS_EN forwards store data to d_out during a write. Bus bit 0 (MSB) is bit [31]/[63] here.

module cmp_mem #(
  parameter int W     = 32,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] MEM [DEPTH];

  // Storage write port; not reset-gated so contents survive reset
  always_ff @(posedge clk) begin
    if (we_i) begin
      MEM[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = MEM[raddr_i];

endmodule

module cmp_node_mem #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256,
  parameter int INST_W     = 32,
  parameter int DATA_W     = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       node0_pc_in,
  output logic [INST_W-1:0] node0_inst_out,
  input  logic [31:0]       node0_addr_in,
  input  logic [DATA_W-1:0] node0_d_in,
  output logic [DATA_W-1:0] node0_d_out,
  input  logic              node0_memEn,
  input  logic              node0_memWrEn,
  input  logic [31:0]       node1_pc_in,
  output logic [INST_W-1:0] node1_inst_out,
  input  logic [31:0]       node1_addr_in,
  input  logic [DATA_W-1:0] node1_d_in,
  output logic [DATA_W-1:0] node1_d_out,
  input  logic              node1_memEn,
  input  logic              node1_memWrEn,
  input  logic [31:0]       node2_pc_in,
  output logic [INST_W-1:0] node2_inst_out,
  input  logic [31:0]       node2_addr_in,
  input  logic [DATA_W-1:0] node2_d_in,
  output logic [DATA_W-1:0] node2_d_out,
  input  logic              node2_memEn,
  input  logic              node2_memWrEn,
  input  logic [31:0]       node3_pc_in,
  output logic [INST_W-1:0] node3_inst_out,
  input  logic [31:0]       node3_addr_in,
  input  logic [DATA_W-1:0] node3_d_in,
  output logic [DATA_W-1:0] node3_d_out,
  input  logic              node3_memEn,
  input  logic              node3_memWrEn,
  output logic              done,
  output logic [31:0]       cycle_count
);

  localparam int IA = $clog2(IMEM_DEPTH);
  localparam int DA = $clog2(DMEM_DEPTH);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  logic [31:0]       pc_s    [4];
  logic [31:0]       addr_s  [4];
  logic [DATA_W-1:0] d_in_s  [4];
  logic              en_s    [4];
  logic              wr_s    [4];
  logic [INST_W-1:0] inst_s  [4];
  logic [DATA_W-1:0] d_out_s [4];

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        all_nop_s;

  assign pc_s   = '{node0_pc_in, node1_pc_in, node2_pc_in, node3_pc_in};
  assign addr_s = '{node0_addr_in, node1_addr_in, node2_addr_in, node3_addr_in};
  assign d_in_s = '{node0_d_in, node1_d_in, node2_d_in, node3_d_in};
  assign en_s   = '{node0_memEn, node1_memEn, node2_memEn, node3_memEn};
  assign wr_s   = '{node0_memWrEn, node1_memWrEn, node2_memWrEn, node3_memWrEn};

  assign node0_inst_out = inst_s[0];
  assign node1_inst_out = inst_s[1];
  assign node2_inst_out = inst_s[2];
  assign node3_inst_out = inst_s[3];
  assign node0_d_out    = d_out_s[0];
  assign node1_d_out    = d_out_s[1];
  assign node2_d_out    = d_out_s[2];
  assign node3_d_out    = d_out_s[3];

  for (genvar n = 0; n < 4; n++) begin : gen_node
    logic [DATA_W-1:0] rd_s;
    logic [DATA_W-1:0] dout_s;
    logic              unused_bits_s;

    // IMEM has no system write path; it is loaded externally
    cmp_mem #(.W(INST_W), .DEPTH(IMEM_DEPTH)) u_imem (
      .clk     (clk),
      .we_i    (1'b0),
      .waddr_i ({IA{1'b0}}),
      .wdata_i ({INST_W{1'b0}}),
      .raddr_i (pc_s[n][IA+1:2]),
      .rdata_o (inst_s[n])
    );

    cmp_mem #(.W(DATA_W), .DEPTH(DMEM_DEPTH)) u_dmem (
      .clk     (clk),
      .we_i    (en_s[n] & wr_s[n]),
      .waddr_i (addr_s[n][DA-1:0]),
      .wdata_i (d_in_s[n]),
      .raddr_i (addr_s[n][DA-1:0]),
      .rdata_o (rd_s)
    );

    // Load data mux: read data on a plain read, forwarded or zero during a write
    always_comb begin
      dout_s = {DATA_W{1'b0}};
      if (en_s[n] && !wr_s[n]) begin
        dout_s = rd_s;
      end else if (en_s[n] && wr_s[n]) begin
`ifdef DMEM_WR_BYPASS_EN
        dout_s = d_in_s[n];
`else
        dout_s = {DATA_W{1'b0}};
`endif
      end else begin
        dout_s = {DATA_W{1'b0}};
      end
    end

    assign d_out_s[n]    = dout_s;
    assign unused_bits_s = ^{pc_s[n][31:IA+2], pc_s[n][1:0], addr_s[n][31:DA]};
  end

  assign all_nop_s = (inst_s[0] == {INST_W{1'b0}}) && (inst_s[1] == {INST_W{1'b0}}) &&
                     (inst_s[2] == {INST_W{1'b0}}) && (inst_s[3] == {INST_W{1'b0}});

  // Completion state and cycle counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The completing edge still counts, so done and the final count appear together
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        cnt_d = cnt_q + 32'd1;
        if (all_nop_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
        cnt_d   = cnt_q;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = 32'd0;
      end
    endcase
  end

  assign done        = (state_q == ST_DONE);
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_cmp_node_mem.sv
// Directed bench for cmp_node_mem with an array-based reference model checked every falling edge.
// Build with DMEM_WR_BYPASS_EN defined to check the forwarding variant.

module tb_cmp_node_mem;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc   [4];
  logic [31:0] addr [4];
  logic [63:0] din  [4];
  logic        en   [4];
  logic        we   [4];
  logic [31:0] inst [4];
  logic [63:0] dout [4];
  logic        done;
  logic [31:0] cnt;

  int checks = 0;
  int fails  = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_imem [4][256];
  logic [63:0] m_dmem [4][256];
  logic        m_done = 1'b0;
  logic [31:0] m_cnt  = 32'd0;

  always #5 clk = ~clk;

  cmp_node_mem dut (
    .clk(clk), .reset(reset),
    .node0_pc_in(pc[0]), .node0_inst_out(inst[0]), .node0_addr_in(addr[0]), .node0_d_in(din[0]),
    .node0_d_out(dout[0]), .node0_memEn(en[0]), .node0_memWrEn(we[0]),
    .node1_pc_in(pc[1]), .node1_inst_out(inst[1]), .node1_addr_in(addr[1]), .node1_d_in(din[1]),
    .node1_d_out(dout[1]), .node1_memEn(en[1]), .node1_memWrEn(we[1]),
    .node2_pc_in(pc[2]), .node2_inst_out(inst[2]), .node2_addr_in(addr[2]), .node2_d_in(din[2]),
    .node2_d_out(dout[2]), .node2_memEn(en[2]), .node2_memWrEn(we[2]),
    .node3_pc_in(pc[3]), .node3_inst_out(inst[3]), .node3_addr_in(addr[3]), .node3_d_in(din[3]),
    .node3_d_out(dout[3]), .node3_memEn(en[3]), .node3_memWrEn(we[3]),
    .done(done), .cycle_count(cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: per-node arrays, count of qualifying edges, sticky completion
  always @(posedge clk) begin
    if (reset && !m_done) begin
      m_cnt <= m_cnt + 32'd1;
      if (m_imem[0][pc[0][9:2]] == 32'd0 && m_imem[1][pc[1][9:2]] == 32'd0 &&
          m_imem[2][pc[2][9:2]] == 32'd0 && m_imem[3][pc[3][9:2]] == 32'd0)
        m_done <= 1'b1;
    end
    for (int n = 0; n < 4; n++)
      if (en[n] && we[n]) m_dmem[n][addr[n][7:0]] <= din[n];
  end

  always @(negedge reset) begin
    m_done <= 1'b0;
    m_cnt  <= 32'd0;
  end

  // Compare all outputs against the model each falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      for (int n = 0; n < 4; n++) begin
        logic [63:0] exp_d;
        exp_d = 64'd0;
        if (en[n] && !we[n]) exp_d = m_dmem[n][addr[n][7:0]];
`ifdef DMEM_WR_BYPASS_EN
        if (en[n] && we[n]) exp_d = din[n];
`endif
        chk($sformatf("model_inst%0d", n), {32'd0, inst[n]}, {32'd0, m_imem[n][pc[n][9:2]]});
        chk($sformatf("model_dout%0d", n), dout[n], exp_d);
      end
      chk("model_done", {63'd0, done}, {63'd0, m_done});
      chk("model_count", {32'd0, cnt}, {32'd0, m_cnt});
    end
  end

  initial begin
    for (int n = 0; n < 4; n++) begin
      pc[n] = 32'd0; addr[n] = 32'd0; din[n] = 64'd0; en[n] = 1'b0; we[n] = 1'b0;
    end
    for (int i = 0; i < 256; i++) begin
      for (int n = 0; n < 4; n++) begin
        m_imem[n][i] <= {8'hA0, 8'(n), 8'h00, 8'(i)};
        m_dmem[n][i] <= {8'hD0, 16'h0, 8'(n), 24'h0, 8'(i)};
      end
      dut.gen_node[0].u_imem.MEM[i] <= {8'hA0, 8'd0, 8'h00, 8'(i)};
      dut.gen_node[1].u_imem.MEM[i] <= {8'hA0, 8'd1, 8'h00, 8'(i)};
      dut.gen_node[2].u_imem.MEM[i] <= {8'hA0, 8'd2, 8'h00, 8'(i)};
      dut.gen_node[3].u_imem.MEM[i] <= {8'hA0, 8'd3, 8'h00, 8'(i)};
      dut.gen_node[0].u_dmem.MEM[i] <= {8'hD0, 16'h0, 8'd0, 24'h0, 8'(i)};
      dut.gen_node[1].u_dmem.MEM[i] <= {8'hD0, 16'h0, 8'd1, 24'h0, 8'(i)};
      dut.gen_node[2].u_dmem.MEM[i] <= {8'hD0, 16'h0, 8'd2, 24'h0, 8'(i)};
      dut.gen_node[3].u_dmem.MEM[i] <= {8'hD0, 16'h0, 8'd3, 24'h0, 8'(i)};
    end
    m_imem[0][0] <= 32'h12345678; dut.gen_node[0].u_imem.MEM[0] <= 32'h12345678;
    m_imem[0][1] <= 32'hCAFEF00D; dut.gen_node[0].u_imem.MEM[1] <= 32'hCAFEF00D;
    for (int n = 0; n < 4; n++) m_imem[n][8] <= 32'd0;
    dut.gen_node[0].u_imem.MEM[8] <= 32'd0;
    dut.gen_node[1].u_imem.MEM[8] <= 32'd0;
    dut.gen_node[2].u_imem.MEM[8] <= 32'd0;
    dut.gen_node[3].u_imem.MEM[8] <= 32'd0;
    #1 reset = 1'b0;
    #1 chk_en = 1'b1;
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_count", {32'd0, cnt}, 64'd0);

    // Zero-latency fetch, PC byte offset and upper bits ignored
    pc[0] = 32'h0;   #1 chk("fetch_pc0", {32'd0, inst[0]}, 64'h12345678);
    pc[0] = 32'h4;   #1 chk("fetch_pc4", {32'd0, inst[0]}, 64'hCAFEF00D);
    pc[0] = 32'h406; #1 chk("fetch_pc406", {32'd0, inst[0]}, 64'hCAFEF00D);

    // Node2 store while reset is held, then read back
    @(posedge clk); #2;
    en[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h0000_0010; din[2] = 64'hDEAD_BEEF_0123_4567;
    @(posedge clk); #2;
    we[2] = 1'b0;
    en[0] = 1'b1; addr[0] = 32'hFFFF_FF10;
    en[1] = 1'b1; addr[1] = 32'h0000_0010;
    en[3] = 1'b1; addr[3] = 32'h0000_0010;
    #1;
    chk("n2_readback", dout[2], 64'hDEAD_BEEF_0123_4567);
    chk("n0_isolated", dout[0], 64'hD000_0000_0000_0010);
    chk("n1_isolated", dout[1], 64'hD000_0001_0000_0010);
    chk("n3_isolated", dout[3], 64'hD000_0003_0000_0010);
    for (int n = 0; n < 4; n++) en[n] = 1'b0;

    // Write enable without memEn does nothing
    we[1] = 1'b1; addr[1] = 32'h0000_0020; din[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 chk("n1_wr_noen_dout", dout[1], 64'd0);
    @(posedge clk); #2;
    we[1] = 1'b0;
    #1 chk("n1_noen_dout", dout[1], 64'd0);
    en[1] = 1'b1;
    #1 chk("n1_unchanged", dout[1], 64'hD000_0001_0000_0020);
    en[1] = 1'b0;

    // Same-cycle write and read on node3
    @(posedge clk); #2;
    en[3] = 1'b1; we[3] = 1'b1; addr[3] = 32'h0000_0033; din[3] = 64'h0123_4567_89AB_CDEF;
`ifdef DMEM_WR_BYPASS_EN
    #1 chk("n3_wr_dout", dout[3], 64'h0123_4567_89AB_CDEF);
`else
    #1 chk("n3_wr_dout", dout[3], 64'd0);
`endif
    @(posedge clk); #2;
    we[3] = 1'b0;
    #1 chk("n3_after_wr", dout[3], 64'h0123_4567_89AB_CDEF);
    en[3] = 1'b0;

    // Completion: node1 busy for 20 edges, then all four at NOP
    pc[0] = 32'h20; pc[1] = 32'h4; pc[2] = 32'h20; pc[3] = 32'h20;
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    chk("busy_done", {63'd0, done}, 64'd0);
    chk("busy_count", {32'd0, cnt}, 64'd20);
    pc[1] = 32'h20;
    @(posedge clk); #2;
    chk("final_done", {63'd0, done}, 64'd1);
    chk("final_count", {32'd0, cnt}, 64'd21);
    pc[1] = 32'h4;
    repeat (10) @(posedge clk);
    #2;
    chk("hold_done", {63'd0, done}, 64'd1);
    chk("hold_count", {32'd0, cnt}, 64'd21);

    // Asynchronous reset mid-cycle; memory contents survive
    #1 reset = 1'b0;
    #1;
    chk("async_done", {63'd0, done}, 64'd0);
    chk("async_count", {32'd0, cnt}, 64'd0);
    en[2] = 1'b1; addr[2] = 32'h0000_0010;
    en[3] = 1'b1; addr[3] = 32'h0000_0033;
    #1;
    chk("n2_persist", dout[2], 64'hDEAD_BEEF_0123_4567);
    chk("n3_persist", dout[3], 64'h0123_4567_89AB_CDEF);
    repeat (2) @(posedge clk);
    #2;
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/cmp_node_mem.md
Name: cmp_node_mem

Overview:
- Memory subsystem for the 4-node Cardinal chip multiprocessor (CMP).
- Holds one instruction memory and one data memory per node.
- Sits between the four processor cores of the CMP and the system. Provides instruction fetch and data load/store, plus program-completion detection and a cycle counter.
- All buses use big-endian bit numbering [0:N-1]; bit 0 is the MSB.

Parameters:
- IMEM_DEPTH, 256, instruction words per node, each INST_W wide.
- DMEM_DEPTH, 256, data words per node, each DATA_W wide.
- INST_W, 32, instruction width.
- DATA_W, 64, data width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- nodeN_pc_in  in  32  node N program counter (byte address); N = 0..3 throughout.
- nodeN_inst_out  out  32  instruction fetched for node N.
- nodeN_addr_in  in  32  node N data address.
- nodeN_d_in  in  64  store data from node N.
- nodeN_d_out  out  64  load data to node N.
- nodeN_memEn  in  1  node N data-memory enable.
- nodeN_memWrEn  in  1  node N write enable; qualified by memEn.
- done  out  1  sticky: all four nodes are fetching the terminating NOP (32'h00000000).
- cycle_count  out  32  clock cycles elapsed since reset release, frozen once done is set.

Behaviour:
- Storage: per node, one array named MEM for IMEM and one array named MEM for DMEM.
  - Contents are not cleared by reset; they are preloaded externally with $readmemh.
  - IMEM: IMEM_DEPTH x INST_W. DMEM: DMEM_DEPTH x DATA_W.
- Instruction fetch:
  - nodeN_inst_out = IMEM_N[nodeN_pc_in[22:29]], combinational with zero latency.
  - Word-addressed: PC bits [30:31] are ignored; bits [0:21] are ignored (address wraps modulo 256).
- Data read:
  - nodeN_d_out = DMEM_N[nodeN_addr_in[24:31]], combinational, when memEn=1 and memWrEn=0.
  - Otherwise nodeN_d_out = 64'h0.
- Data write:
  - At posedge clk, if memEn=1 and memWrEn=1, DMEM_N[addr_in[24:31]] <= d_in.
  - memWrEn=1 with memEn=0 performs no write.
  - Address bits [0:23] are ignored.
- Nodes are fully independent. Simultaneous accesses by different nodes never interact; there is no shared port.
- Writes are allowed during reset. Memory contents persist across reset.
- Reset (reset=0, asynchronous): done <= 0, cycle_count <= 0. Memory read outputs remain combinational.
- Cycle counter: each posedge with reset=1 and done=0, cycle_count <= cycle_count + 1, wrapping modulo 2^32. It holds its value while done=1.
- Completion:
  - At posedge with reset=1, if all four nodeN_inst_out == 32'h00000000, done <= 1.
  - done is sticky until the next reset.
  - The cycle_count value captured on that same edge still increments, so done and the final count appear together.
  - Three of four nodes at NOP does not set done.
- Reset asserted mid-operation: done and cycle_count clear immediately. An in-flight write on the same edge as the reset assertion is still performed (the write path is not reset-gated).

Optional Feature:
- Macro DMEM_WR_BYPASS_EN.
- When defined: if memEn=1 and memWrEn=1, nodeN_d_out = nodeN_d_in (write-through forwarding) in the same cycle.
- When undefined: nodeN_d_out = 64'h0 during a write, as specified above.
- Write behaviour into the array is identical in both builds.

Test Plan:
- Preload IMEM0[0]=32'h12345678, IMEM0[1]=32'hCAFEF00D; drive node0_pc_in=32'h0 then 32'h4 -> node0_inst_out=32'h12345678 then 32'hCAFEF00D with no clock needed. pc=32'h406 -> IMEM0[1].
- Node2: memEn=1, memWrEn=1, addr=32'h0000_0010, d_in=64'hDEAD_BEEF_0123_4567, one clock; then memWrEn=0 -> node2_d_out=64'hDEADBEEF01234567. Other nodes' DMEM[16] are unchanged.
- memEn=0 with memWrEn=1 on node1 across a clock -> DMEM1 unchanged and node1_d_out=0. With memEn=0 alone -> d_out=0.
- Same-cycle write and read of one address on node3: without DMEM_WR_BYPASS_EN -> d_out=0; with it -> d_out equals d_in. The following cycle's read returns the new data in both builds.
- Release reset. Three nodes fetch 0 while node1 is nonzero for 20 cycles -> done=0 and cycle_count=20. Node1 then fetches 0 -> done=1 with cycle_count=21, held constant for the next 10 cycles.
- Assert reset (low) asynchronously mid-count -> done=0 and cycle_count=0 immediately, before the next clock edge; DMEM contents are preserved.
